// File: rtl/regbank_mp_if.sv
// Bus bundle for regbank_mp: two write ports, packed read ports, bulk-clear request/busy.
interface regbank_mp_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic                     wr_en0;
  logic [ADDR_W-1:0]        wr_addr0;
  logic [WIDTH-1:0]         wr_data0;
  logic                     wr_en1;
  logic [ADDR_W-1:0]        wr_addr1;
  logic [WIDTH-1:0]         wr_data1;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic                     clr_req;
  logic                     busy;

  modport master (
    output wr_en0, wr_addr0, wr_data0,
    output wr_en1, wr_addr1, wr_data1,
    output rd_addr, clr_req,
    input  rd_data, busy
  );

  modport slave (
    input  wr_en0, wr_addr0, wr_data0,
    input  wr_en1, wr_addr1, wr_data1,
    input  rd_addr, clr_req,
    output rd_data, busy
  );
endinterface

// File: rtl/regbank_mp.sv
// Parametrised multi-port register file: two prioritised write ports, combinational reads
// with optional same-cycle bypass, optional hardwired-zero r0 and a sequential bulk clear.
module regbank_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic          clk,
  input  logic          reset,
  regbank_mp_if.slave   bus
);

  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              idle;
  logic              we0_ok;
  logic              we1_ok;
  logic [ADDR_W-1:0] ra;
  logic [WIDTH-1:0]  rval;
  logic [NUM_RD*WIDTH-1:0] rd_data;

  // Out-of-range addresses and a locked r0 are neither writable nor readable.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DepthW) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign idle   = (state_q == StIdle);
  assign we0_ok = bus.wr_en0 && addr_ok(bus.wr_addr0);
  assign we1_ok = bus.wr_en1 && addr_ok(bus.wr_addr1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // Port 1 is assigned last so it wins an address collision.
          if (we0_ok) mem_q[bus.wr_addr0] <= bus.wr_data0;
          if (we1_ok) mem_q[bus.wr_addr1] <= bus.wr_data1;
          if (bus.clr_req) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == LastIdx) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rval    = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rval = '0;
      if (addr_ok(ra)) begin
        rval = mem_q[ra];
        if ((BYPASS != 0) && idle) begin
          if (we0_ok && (bus.wr_addr0 == ra)) rval = bus.wr_data0;
          if (we1_ok && (bus.wr_addr1 == ra)) rval = bus.wr_data1;
        end
      end
      rd_data[i*WIDTH +: WIDTH] = rval;
    end
  end

  assign bus.rd_data = rd_data;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Directed + random bench for regbank_mp: config A (32 deep, bypass) and config B
// (20 deep, no bypass, zero r0) share stimulus and are checked against an array model.
module tb_regbank_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we0, we1, clr;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m [2][32];
  int          cpos [2];

  always #5 clk = ~clk;

  regbank_mp_if #(.WIDTH(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  regbank_mp_if #(.WIDTH(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

  assign ifa.wr_en0 = we0;  assign ifb.wr_en0 = we0;
  assign ifa.wr_addr0 = wa0; assign ifb.wr_addr0 = wa0;
  assign ifa.wr_data0 = wd0; assign ifb.wr_data0 = wd0;
  assign ifa.wr_en1 = we1;  assign ifb.wr_en1 = we1;
  assign ifa.wr_addr1 = wa1; assign ifb.wr_addr1 = wa1;
  assign ifa.wr_data1 = wd1; assign ifb.wr_data1 = wd1;
  assign ifa.rd_addr = ra;  assign ifb.rd_addr = ra;
  assign ifa.clr_req = clr; assign ifb.clr_req = clr;

  regbank_mp #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(0)
  ) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  regbank_mp #(
    .WIDTH(32), .DEPTH(20), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  function automatic int depth_of(int c);
    return (c == 0) ? 32 : 20;
  endfunction

  function automatic bit wr_ok(int c, logic [4:0] a);
    return (int'(a) < depth_of(c)) && !(c == 1 && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int c, logic [4:0] a);
    logic [31:0] v;
    if (!wr_ok(c, a)) return '0;
    v = m[c][a];
    if (c == 0 && cpos[c] < 0) begin
      if (we0 && wa0 == a) v = wd0;
      if (we1 && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) m[c][i] = '0;
      cpos[c] = -1;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (cpos[c] < 0) begin
        if (we0 && wr_ok(c, wa0)) m[c][wa0] = wd0;
        if (we1 && wr_ok(c, wa1)) m[c][wa1] = wd1;
        if (clr) cpos[c] = 0;
      end else begin
        m[c][cpos[c]] = '0;
        cpos[c]++;
        if (cpos[c] == depth_of(c)) cpos[c] = -1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #1;
    chk($sformatf("a_rd0@%0d", ra[4:0]), ifa.rd_data[31:0],  exp_rd(0, ra[4:0]));
    chk($sformatf("a_rd1@%0d", ra[9:5]), ifa.rd_data[63:32], exp_rd(0, ra[9:5]));
    chk($sformatf("b_rd0@%0d", ra[4:0]), ifb.rd_data[31:0],  exp_rd(1, ra[4:0]));
    chk($sformatf("b_rd1@%0d", ra[9:5]), ifb.rd_data[63:32], exp_rd(1, ra[9:5]));
    chk("a_busy", {31'b0, ifa.busy}, {31'b0, cpos[0] >= 0});
    chk("b_busy", {31'b0, ifb.busy}, {31'b0, cpos[1] >= 0});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep();
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)};
      check_all();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    we0 = 0; we1 = 0; clr = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra = '0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential fill k -> 10*k, reading the address being written
    for (int k = 0; k < 32; k++) begin
      we0 = 1; wa0 = 5'(k); wd0 = 32'(10 * k);
      ra = {5'(k), 5'(k)};
      check_all();
      tick();
    end
    we0 = 0;
    for (int k = 0; k < 31; k++) begin
      ra = {5'(k + 1), 5'(k)};
      check_all();
    end

    // Same-address collision: port 1 wins, bypass on A shows it
    we0 = 1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1; wa1 = 5'd5; wd1 = 32'h22;
    ra = {5'd6, 5'd5};
    check_all();
    chk("a_bypass_collide", ifa.rd_data[31:0], 32'h22);
    tick();
    we0 = 0; we1 = 0;
    check_all();
    chk("a_reg5", ifa.rd_data[31:0], 32'h22);
    chk("b_reg5", ifb.rd_data[31:0], 32'h22);

    // Hardwired zero on B
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1; wa1 = 5'd1; wd1 = 32'h0000_BEEF;
    tick();
    we0 = 0; we1 = 0;
    ra = {5'd1, 5'd0};
    check_all();
    chk("b_zero_reg", ifb.rd_data[31:0], 32'h0);
    chk("b_reg1", ifb.rd_data[63:32], 32'h0000_BEEF);
    chk("a_reg0", ifa.rd_data[31:0], 32'hFFFF_FFFF);

    // Out-of-range write on B
    we0 = 1; wa0 = 5'd25; wd0 = 32'hDEAD_0025;
    tick();
    we0 = 0;
    ra = {5'd25, 5'd25};
    check_all();
    chk("b_oob_read", ifb.rd_data[31:0], 32'h0);
    sweep();

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 31)); wd1 = $urandom;
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      ra = 10'($urandom);
      if ($urandom_range(0, 2) == 0) ra[4:0] = wa1;
      clr = ($urandom_range(0, 39) == 0);
      check_all();
      tick();
    end
    we0 = 0; we1 = 0; clr = 0;
    n = 0;
    while ((ifa.busy || ifb.busy) && n < 100) begin
      check_all();
      tick();
      n++;
    end
    chk("drain_idle", {31'b0, ifa.busy | ifb.busy}, 32'h0);

    // Fill with pattern then bulk clear; busy must last DEPTH cycles
    for (int k = 0; k < 32; k++) begin
      we0 = 1; wa0 = 5'(k); wd0 = 32'hA5A5_A5A5;
      check_all();
      tick();
    end
    we0 = 0;
    clr = 1;
    check_all();
    tick();
    clr = 0;
    n = 0;
    while (ifa.busy && n < 100) begin
      if (n == 3) begin
        we0 = 1; wa0 = 5'd31; wd0 = 32'h1234;
      end else begin
        we0 = 0;
      end
      ra = 10'($urandom);
      check_all();
      tick();
      n++;
    end
    we0 = 0;
    chk("a_busy_len", 32'(n), 32'd32);
    ra = {5'd31, 5'd31};
    check_all();
    chk("a_reg31_cleared", ifa.rd_data[31:0], 32'h0);
    sweep();

    // Reset aborts a clear in progress
    for (int k = 0; k < 32; k++) begin
      we0 = 1; wa0 = 5'(k); wd0 = 32'h5A00_0000 | 32'(k);
      tick();
    end
    we0 = 0;
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 10; i++) begin
      ra = 10'($urandom);
      check_all();
      tick();
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    ra = {5'd30, 5'd20};
    check_all();
    chk("a_busy_abort", {31'b0, ifa.busy}, 32'h0);
    chk("a_reg30_abort", ifa.rd_data[63:32], 32'h0);
    sweep();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    we0 = 1; wa0 = 5'd7; wd0 = 32'h0000_0077;
    tick();
    we0 = 0;
    ra = {5'd7, 5'd7};
    check_all();
    chk("a_reg7_after_reset", ifa.rd_data[31:0], 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised successor to the 32x32 two-read/one-write register bank.
- Generalises width, depth and read-port count, and adds a second write port with fixed priority.
- Adds an optional write-to-read bypass, an optional hardwired-zero register 0, and a sequential bulk-clear engine with a busy flag.
- Sits beside the datapath as the architectural register file; reads are combinational, writes are clocked.

Parameters:
- WIDTH, 32: data bits per register.
- DEPTH, 32: number of registers; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 5: address bits.
- NUM_RD, 2: number of read ports, 1..8.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- wr_en0  in  1  write enable, port 0.
- wr_addr0  in  ADDR_W  write address, port 0.
- wr_data0  in  WIDTH  write data, port 0.
- wr_en1  in  1  write enable, port 1 (higher priority).
- wr_addr1  in  ADDR_W  write address, port 1.
- wr_data1  in  WIDTH  write data, port 1.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*WIDTH  packed read data; port i uses bits [i*WIDTH +: WIDTH].
- clr_req  in  1  one-cycle request to start a bulk clear.
- busy  out  1  high while a bulk clear is in progress.

Behaviour:
- Reset (reset=0, asynchronous): all registers go to 0, the FSM goes to IDLE, the clear counter goes to 0, busy=0. rd_data then reflects zeros combinationally.
- Write: on a rising clk with reset=1 and FSM in IDLE, each enabled port stores its data at its address.
  - If both ports are enabled to the same address, port 1's data is stored.
  - Addresses >= DEPTH: write is ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Read: combinational, zero clock latency. rd_data[i] = reg[rd_addr[i]].
  - Addresses >= DEPTH read 0.
  - With ZERO_REG=1, address 0 reads 0.
- Bypass (BYPASS=1, FSM in IDLE): if wr_enX=1 and wr_addrX equals rd_addr[i] (a valid, non-zero-locked address), rd_data[i] returns wr_dataX in the same cycle. Port 1 wins over port 0.
- With BYPASS=0, a written value appears on reads from the cycle after the edge.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr_req=1 sampled at a rising edge. Write ports are still honoured on that same edge. Counter is set to 0.
  - CLEAR: on each rising edge, reg[counter] is set to 0 and the counter increments.
  - CLEAR -> IDLE: on the edge that clears register DEPTH-1. The counter returns to 0.
  - CLEAR therefore lasts exactly DEPTH cycles.
- busy: registered, equals (state == CLEAR). It rises in the cycle after clr_req is sampled and falls after DEPTH cycles.
- During CLEAR:
  - All writes are dropped; no stalling or queueing.
  - Bypass is disabled.
  - Reads return current stored contents, so registers below the counter already read 0.
  - clr_req is ignored.
- Reset mid-clear aborts immediately; all registers read 0 and busy=0.
- Unsigned data; no arithmetic beyond ADDR_W-bit counter increment. The counter never exceeds DEPTH-1.

Test Plan:
- Reset, then for k=0..31 write 10*k via port 0, one per cycle; read pairs (k, k+1) on two read ports -> rd_data equals 10*k and 10*(k+1) for all k.
- Same edge: wr_en0 with addr 5, data 0x11; wr_en1 with addr 5, data 0x22 -> reg[5]=0x22. With BYPASS=1 and rd_addr[0]=5 in that cycle, rd_data[0]=0x22.
- ZERO_REG=1: write 0xFFFF_FFFF to address 0 -> address 0 reads 0; address 1 is written normally.
- Fill all registers with 0xA5A5_A5A5 and pulse clr_req -> busy=1 for exactly 32 cycles. During clear, a write of 0x1234 to address 31 at cycle 3 is dropped. After busy falls, all registers read 0.
- Start clear, assert reset=0 at cycle 10 of CLEAR -> busy=0 and all registers 0 immediately. After release, a write to address 7 succeeds on the next edge.
- DEPTH=20, ADDR_W=5: write to address 25 -> ignored; reading address 25 returns 0; registers 0..19 are unaffected.
